// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared OTTER types: opcodes, funct3 codes, memory sizes, dmem FSM states
package otter_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } func3_load_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } func3_store_t;

    // Encoding 2'b11 is reserved and is handled like WORD everywhere.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } dmem_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        if (size == BYTE)      return 1'b0;
        else if (size == HALF) return off[0];
        else                   return off != 2'b00;
    endfunction

    function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] off);
        if (size == BYTE)      return off;
        else if (size == HALF) return {off[1], 1'b0};
        else                   return 2'b00;
    endfunction

endpackage

// File: rtl/otter_load_align.sv
// rtl/otter_load_align.sv - selects the addressed byte/half of a word and sign- or zero-extends it
module otter_load_align
    import otter_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        zext_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        if (size_i == BYTE)
            data_o = zext_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        else if (size_i == HALF)
            data_o = zext_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end

endmodule

// File: rtl/otter_dmem_responder.sv
// rtl/otter_dmem_responder.sv - multi-cycle data memory with wait states; DMEM_MISALIGN_TRAP_EN enables misalign trap
module otter_dmem_responder
    import otter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MEM_READ2,
    input  logic        MEM_WRITE2,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_SIGN,
    output logic [31:0] MEM_DOUT2,
    output logic        MEM_RESP_VALID,
    output logic        MEM_BUSY,
    output logic        MEM_ERR
);

    logic [31:0] mem [2**ADDR_WIDTH];

    dmem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           din_q, dout_q, dout_d;
    logic [1:0]            size_q;
    logic                  sign_q, wr_q;

    logic        req, do_op, trap, write_en;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata, rdata, load_data;
    logic [ADDR_WIDTH-1:0] idx;
    logic        unused_addr;

    assign unused_addr = ^MEM_ADDR2[31:ADDR_WIDTH+2];
    assign req   = MEM_READ2 | MEM_WRITE2;
    assign do_op = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign idx   = addr_q[ADDR_WIDTH+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(size_q, addr_q[1:0]);
    assign off  = addr_q[1:0];
`else
    assign trap = 1'b0;
    assign off  = force_align(size_q, addr_q[1:0]);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            din_q   <= 32'h0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            if (state_q == IDLE && req) begin
                addr_q <= MEM_ADDR2[ADDR_WIDTH+1:0];
                din_q  <= MEM_DIN2;
                size_q <= MEM_SIZE;
                sign_q <= MEM_SIGN;
                wr_q   <= MEM_WRITE2;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = ACCESS;
                cnt_d   = 4'(WAIT_STATES);
            end
            ACCESS: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MEM_RESP_VALID = (state_q == RESP);
        MEM_BUSY       = (state_q == ACCESS) || (state_q == IDLE && req);
        MEM_ERR        = (state_q == RESP) && trap;
        MEM_DOUT2      = dout_q;
    end

    always_comb begin
        be    = 4'b1111;
        wdata = din_q;
        if (size_q == BYTE) begin
            be    = 4'b0001 << off;
            wdata = {4{din_q[7:0]}};
        end else if (size_q == HALF) begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{din_q[15:0]}};
        end
    end

    assign write_en = do_op && wr_q && !trap;
    assign rdata    = mem[idx];

    otter_load_align u_align (
        .word_i (rdata),
        .off_i  (off),
        .size_i (size_q),
        .zext_i (sign_q),
        .data_o (load_data)
    );

    // Stores and trapped accesses report zero; otherwise the load result is held until the next response.
    always_comb begin
        dout_d = dout_q;
        if (do_op) dout_d = (wr_q || trap) ? 32'h0 : load_data;
    end

    // Array has no reset; reset forces IDLE asynchronously, so an aborted ACCESS never writes.
    always_ff @(posedge CLK) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: doc/otter_dmem_responder.md
OTTER_DMEM_RESPONDER -- requirements
Module: otter_dmem_responder

Interface
REQ-001 Parameter ADDR_WIDTH SHALL be: default 14, word-address width; array depth 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES SHALL be: default 1, extra access cycles, legal range 0..15.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 MEM_READ2  in  1  load request from memory stage.
REQ-006 MEM_WRITE2  in  1  store request from memory stage.
REQ-007 MEM_ADDR2  in  32  byte address.
REQ-008 MEM_DIN2  in  32  store data, right-aligned.
REQ-009 MEM_SIZE  in  2  0 byte, 1 half, 2 word, 3 reserved.
REQ-010 MEM_SIGN  in  1  1 = zero-extend (funct3[2]), 0 = sign-extend.
REQ-011 MEM_DOUT2  out  32  extended load data.
REQ-012 MEM_RESP_VALID  out  1  one-cycle pulse marking completion.
REQ-013 MEM_BUSY  out  1  pipeline stall request.
REQ-014 MEM_ERR  out  1  misaligned-access flag, valid with MEM_RESP_VALID.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RESP; any other encoding SHALL return to IDLE.
REQ-016 In IDLE, a request (READ2 or WRITE2 high) SHALL be accepted: address, data, size, sign, op latched; next state ACCESS with counter = WAIT_STATES.
REQ-017 In ACCESS, counter SHALL decrement each cycle; when counter = 0 the array operation SHALL occur that cycle and next state SHALL be RESP.
REQ-018 In RESP, MEM_RESP_VALID SHALL be 1 for exactly one cycle; next state IDLE; no request accepted in RESP.
REQ-019 Latency: request in cycle T SHALL give MEM_RESP_VALID in cycle T+2+WAIT_STATES.
REQ-020 MEM_BUSY SHALL be 1 when (IDLE and request) or ACCESS; 0 in RESP and idle IDLE.
REQ-021 Inputs SHALL be ignored except in IDLE.
REQ-022 Both READ2 and WRITE2 high SHALL perform the write only; MEM_DOUT2 = 0 for that response.
REQ-023 Word index SHALL be addr[ADDR_WIDTH+1:2]; upper address bits ignored (wrap-around).
REQ-024 Store lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0}+1..+0; word/reserved -> all four; other bytes unchanged.
REQ-025 Load: selected byte/half SHALL be right-aligned and sign- or zero-extended per MEM_SIGN; word/reserved SHALL pass 32 bits.
REQ-026 MEM_DOUT2 SHALL hold its value until the next response; stores SHALL set it to 0.

Reset
REQ-027 RST_N low SHALL force IDLE, counter 0, MEM_DOUT2 0, MEM_RESP_VALID 0, MEM_ERR 0, MEM_BUSY 0 immediately.
REQ-028 Reset during ACCESS SHALL abort the operation with no array write; array contents SHALL NOT be reset.

Configuration
REQ-029 With DMEM_MISALIGN_TRAP_EN defined, half at odd address or word with addr[1:0] != 0 SHALL suppress the write, return MEM_DOUT2 = 0, and raise MEM_ERR with MEM_RESP_VALID.
REQ-030 Without DMEM_MISALIGN_TRAP_EN, misaligned low bits SHALL be forced to alignment (half: addr[0]=0; word: addr[1:0]=0) and MEM_ERR SHALL tie to 0.

Structure
REQ-031 Shared package otter_pkg SHALL hold opcode_t, func3 enums, mem_size_t (BYTE, HALF, WORD) and dmem_state_t.
REQ-032 Lane selection and extension SHALL be a sub-module otter_load_align (combinational); FSM and array in the top.

Verification
REQ-033 WAIT_STATES=1: store word 0xDEADBEEF @0x10 (T=0), load word @0x10 -> RESP_VALID at T=3, DOUT 0xDEADBEEF, BUSY high cycles 0-2.
REQ-034 After REQ-033: load byte @0x13 SIGN=0 -> 0xFFFFFFDE; SIGN=1 -> 0x000000DE; load half @0x12 SIGN=0 -> 0xFFFFDEAD.
REQ-035 Store byte 0x5A @0x11 then load word @0x10 -> 0xDEAD5AEF.
REQ-036 Misaligned load word @0x12: with macro -> ERR=1, DOUT 0; without -> DOUT 0xDEAD5AEF, ERR 0.
REQ-037 Store word 0x12345678 @0x20, RST_N low during ACCESS, then load @0x20 -> previous contents unchanged; outputs 0 during reset.
REQ-038 Read and write asserted together @0x30 with 0xCAFEF00D -> DOUT 0; later load @0x30 -> 0xCAFEF00D.
